// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive-side FIFO.
// Entry layout and the default depth / flow-control thresholds live here so
// the FIFO control block and its storage agree on a single definition.
package uart_pkg;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_RTS_HI = 12;
    localparam int DEFAULT_RTS_LO = 4;

    // One received word plus the status captured with it.
    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_fifo_entry_t;

    // Parity error: data parity disagrees with the received parity bit,
    // reported only when checking is enabled.
    function automatic logic parity_error(input logic check_en, input logic [8:0] word);
        return check_en & ((^word[7:0]) != word[8]);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH register array with one synchronous write port
// and one asynchronous (combinational) read port. Holds no control state.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = $bits(rx_fifo_entry_t)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on each accepted push.
    // NOTE: storage has no reset; validity is tracked by the level counter, and
    //       resetting an array would turn it into a large reset-fanout flop bank.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    //       pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO behind the UART receiver. Captures each
// completed word with frame/parity status, tracks fill level, latches overrun
// on a push into a full FIFO, and drives RTS from level with hysteresis.
// Build option: UART_RX_FIFO_ERR_FLAGS_EN stores the per-entry error flags;
// without it entries are data-only and the flag outputs read 0.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int RTS_HI = DEFAULT_RTS_HI,
    parameter int RTS_LO = DEFAULT_RTS_LO
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_rx_done,
    input  logic [8:0]               i_rx_word,
    input  logic                     i_rx_frame_error,
    input  logic                     i_parity_check_enable,
    input  logic                     i_hw_flow_control_enable,
    input  logic                     i_rd_req,
    output logic [7:0]               o_rd_data,
    output logic                     o_rd_frame_error,
    output logic                     o_rd_parity_error,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overrun,
    input  logic                     i_overrun_clear,
    output logic                     o_rts
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef UART_RX_FIFO_ERR_FLAGS_EN
    localparam int EW = $bits(rx_fifo_entry_t);
`else
    localparam int EW = 8;
`endif

    logic           done_q;
    logic           armed_q;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic           overrun_q;
    logic           rts_q;

    logic           push;
    logic           pop;
    logic           wr_en;
    logic           drop;
    logic           empty;
    logic           full;

    rx_fifo_entry_t wr_entry;
    rx_fifo_entry_t rd_entry;
    logic [EW-1:0]  wr_bits;
    logic [EW-1:0]  rd_bits;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    // armed_q is low only in the first cycle after reset, so a done level held
    // through reset release is absorbed into done_q without producing a push.
    assign push  = armed_q & i_rx_done & ~done_q;
    assign pop   = i_rd_req & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    assign wr_entry = '{frame_err:  i_rx_frame_error,
                        parity_err: parity_error(i_parity_check_enable, i_rx_word),
                        data:       i_rx_word[7:0]};

`ifdef UART_RX_FIFO_ERR_FLAGS_EN
    assign wr_bits = wr_entry;
`else
    assign wr_bits = wr_entry.data;
    logic unused_flags;
    assign unused_flags = ^{wr_entry.frame_err, wr_entry.parity_err};
`endif

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_bits),
        .rd_addr (rd_ptr),
        .rd_data (rd_bits)
    );

    // Unpack the head entry; flags read as 0 when they are not stored.
    // NOTE: every always_comb output gets a default first so no path can
    //       leave it unassigned and infer a latch.
    always_comb begin
        rd_entry = '0;
`ifdef UART_RX_FIFO_ERR_FLAGS_EN
        rd_entry = rd_bits;
`else
        rd_entry.data = rd_bits;
`endif
    end

    // Head is forced to 0 when empty so stale storage never shows on the bus.
    assign o_rd_data         = empty ? 8'h00 : rd_entry.data;
    assign o_rd_frame_error  = ~empty & rd_entry.frame_err;
    assign o_rd_parity_error = ~empty & rd_entry.parity_err;
    assign o_empty           = empty;
    assign o_full            = full;
    assign o_level           = level;
    assign o_overrun         = overrun_q;
    assign o_rts             = rts_q & i_hw_flow_control_enable;

    // Edge detector on the receiver's done level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            done_q  <= i_rx_done;
            armed_q <= 1'b1;
        end
    end

    // Pointers and level: push and pop are independent, level nets them out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overrun; a new drop wins over a clear in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (i_overrun_clear) begin
            overrun_q <= 1'b0;
        end
    end

    // RTS hysteresis flag follows level whether or not flow control is on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rts_q <= 1'b0;
        end else if (level >= LW'(RTS_HI)) begin
            rts_q <= 1'b1;
        end else if (level <= LW'(RTS_LO)) begin
            rts_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo. A table of single-cycle
// vectors covers push/pop/parity/edge-detect behaviour; hand-written
// sequences cover fill, overrun, RTS hysteresis, full push+pop and reset.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx_done = 1'b0;
    logic [8:0] i_rx_word = '0;
    logic       i_rx_frame_error = 1'b0;
    logic       i_parity_check_enable = 1'b0;
    logic       i_hw_flow_control_enable = 1'b1;
    logic       i_rd_req = 1'b0;
    logic       i_overrun_clear = 1'b0;
    logic [7:0] o_rd_data;
    logic       o_rd_frame_error;
    logic       o_rd_parity_error;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_level;
    logic       o_overrun;
    logic       o_rts;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo dut (
        .i_clk                    (i_clk),
        .i_rst                    (i_rst),
        .i_rx_done                (i_rx_done),
        .i_rx_word                (i_rx_word),
        .i_rx_frame_error         (i_rx_frame_error),
        .i_parity_check_enable    (i_parity_check_enable),
        .i_hw_flow_control_enable (i_hw_flow_control_enable),
        .i_rd_req                 (i_rd_req),
        .o_rd_data                (o_rd_data),
        .o_rd_frame_error         (o_rd_frame_error),
        .o_rd_parity_error        (o_rd_parity_error),
        .o_empty                  (o_empty),
        .o_full                   (o_full),
        .o_level                  (o_level),
        .o_overrun                (o_overrun),
        .i_overrun_clear          (i_overrun_clear),
        .o_rts                    (o_rts)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       done;
        logic [8:0] word;
        logic       fe_in;
        logic       par_en;
        logic       rd;
        logic       e_empty;
        logic [4:0] e_level;
        logic [7:0] e_data;
        logic       e_fe;
        logic       e_pe;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        //          done word    fe par rd | empty lvl data  fe pe
        vecs[0]  = '{0, 9'h000, 0, 1, 0,    1, 0, 8'h00, 0, 0};
        vecs[1]  = '{1, 9'h055, 0, 1, 0,    0, 1, 8'h55, 0, 0};
        vecs[2]  = '{1, 9'h055, 0, 1, 0,    0, 1, 8'h55, 0, 0};
        vecs[3]  = '{1, 9'h055, 0, 1, 0,    0, 1, 8'h55, 0, 0};
        vecs[4]  = '{0, 9'h000, 0, 1, 0,    0, 1, 8'h55, 0, 0};
        vecs[5]  = '{1, 9'h001, 1, 1, 0,    0, 2, 8'h55, 0, 0};
        vecs[6]  = '{0, 9'h000, 0, 1, 1,    0, 1, 8'h01, 1, 1};
        vecs[7]  = '{1, 9'h001, 0, 0, 1,    0, 1, 8'h01, 0, 0};
        vecs[8]  = '{0, 9'h000, 0, 1, 1,    1, 0, 8'h00, 0, 0};
        vecs[9]  = '{0, 9'h000, 0, 1, 1,    1, 0, 8'h00, 0, 0};
        vecs[10] = '{1, 9'h107, 0, 1, 0,    0, 1, 8'h07, 0, 0};
        vecs[11] = '{0, 9'h000, 0, 1, 1,    1, 0, 8'h00, 0, 0};
        vecs[12] = '{1, 9'h180, 0, 1, 1,    0, 1, 8'h80, 0, 0};
        vecs[13] = '{0, 9'h000, 0, 1, 0,    0, 1, 8'h80, 0, 0};
        vecs[14] = '{0, 9'h000, 0, 1, 1,    1, 0, 8'h00, 0, 0};
        vecs[15] = '{1, 9'h100, 0, 1, 0,    0, 1, 8'h00, 0, 1};
        vecs[16] = '{0, 9'h000, 0, 1, 1,    1, 0, 8'h00, 0, 0};

        // Reset values while reset is held.
        step();
        step();
        check("rst empty", o_empty, 1);
        check("rst full", o_full, 0);
        check("rst level", o_level, 0);
        check("rst overrun", o_overrun, 0);
        check("rst rts", o_rts, 0);
        check("rst data", o_rd_data, 0);
        i_rst = 1'b0;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 17; i++) begin
            i_rx_done             = vecs[i].done;
            i_rx_word             = vecs[i].word;
            i_rx_frame_error      = vecs[i].fe_in;
            i_parity_check_enable = vecs[i].par_en;
            i_rd_req              = vecs[i].rd;
            step();
            check($sformatf("vec%0d empty", i), o_empty, vecs[i].e_empty);
            check($sformatf("vec%0d level", i), o_level, vecs[i].e_level);
            check($sformatf("vec%0d data", i), o_rd_data, vecs[i].e_data);
            check($sformatf("vec%0d frame_err", i), o_rd_frame_error, FLAGS & vecs[i].e_fe);
            check($sformatf("vec%0d parity_err", i), o_rd_parity_error, FLAGS & vecs[i].e_pe);
        end
        i_rx_done = 1'b0;
        i_rd_req  = 1'b0;
        i_rx_frame_error = 1'b0;
        i_parity_check_enable = 1'b1;

        // Fill to 16 with flow control on; RTS rises one cycle after level 12.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(i);
            i_rx_done = 1'b1;
            i_rx_word = {^d, d};
            step();
            exp_q.push_back(d);
            if (i == 11) begin
                check("fill level 12", o_level, 12);
                check("rts lag at 12", o_rts, 0);
            end
            i_rx_done = 1'b0;
            step();
            if (i == 10) check("rts at 11", o_rts, 0);
            if (i == 11) check("rts after 12", o_rts, 1);
        end
        check("full flag", o_full, 1);
        check("full level", o_level, 16);
        check("full no overrun", o_overrun, 0);
        check("full head", o_rd_data, 8'h10);

        // Push into full FIFO: dropped, overrun set; then clear.
        i_rx_done = 1'b1;
        i_rx_word = 9'h0EE;
        step();
        check("drop overrun", o_overrun, 1);
        check("drop level", o_level, 16);
        check("drop head", o_rd_data, 8'h10);
        i_rx_done = 1'b0;
        i_overrun_clear = 1'b1;
        step();
        check("overrun clear", o_overrun, 0);
        // Drop coincident with clear: set wins.
        i_rx_done = 1'b1;
        i_rx_word = 9'h1EF;
        step();
        check("overrun set beats clear", o_overrun, 1);
        i_rx_done = 1'b0;
        step();
        check("overrun clear 2", o_overrun, 0);
        i_overrun_clear = 1'b0;

        // Push and pop on a full FIFO: level holds, no overrun, tail gets word.
        i_rx_done = 1'b1;
        i_rx_word = {^8'hA5, 8'hA5};
        i_rd_req  = 1'b1;
        step();
        void'(exp_q.pop_front());
        exp_q.push_back(8'hA5);
        i_rx_done = 1'b0;
        i_rd_req  = 1'b0;
        check("full pushpop level", o_level, 16);
        check("full pushpop overrun", o_overrun, 0);
        check("full pushpop head", o_rd_data, exp_q[0]);

        // Pop down to 5; RTS must hold through the hysteresis band.
        for (int k = 0; k < 11; k++) begin
            i_rd_req = 1'b1;
            step();
            void'(exp_q.pop_front());
            check($sformatf("pop%0d data", k), o_rd_data, exp_q[0]);
        end
        i_rd_req = 1'b0;
        step();
        check("level 5", o_level, 5);
        check("rts held at 5", o_rts, 1);
        i_hw_flow_control_enable = 1'b0;
        #1;
        check("rts gated off", o_rts, 0);
        i_hw_flow_control_enable = 1'b1;
        #1;
        check("rts gated on", o_rts, 1);
        i_rd_req = 1'b1;
        step();
        void'(exp_q.pop_front());
        i_rd_req = 1'b0;
        check("level 4", o_level, 4);
        check("rts lag at 4", o_rts, 1);
        step();
        check("rts cleared at 4", o_rts, 0);

        // Drain remaining entries; the last one must be the word written while full.
        check("tail word", exp_q[3], 8'hA5);
        while (exp_q.size() > 0) begin
            check("drain data", o_rd_data, exp_q[0]);
            i_rd_req = 1'b1;
            step();
            void'(exp_q.pop_front());
        end
        i_rd_req = 1'b0;
        check("drained empty", o_empty, 1);
        check("drained level", o_level, 0);

        // Reset mid-fill discards contents immediately.
        for (int i = 0; i < 3; i++) begin
            i_rx_done = 1'b1;
            i_rx_word = 9'h033;
            step();
            i_rx_done = 1'b0;
            step();
        end
        check("prefill level", o_level, 3);
        i_rx_done = 1'b1;
        i_rst = 1'b1;
        #1;
        check("async rst empty", o_empty, 1);
        check("async rst level", o_level, 0);
        check("async rst data", o_rd_data, 0);
        step();
        step();
        i_rst = 1'b0;
        step();
        step();
        check("done held through reset", o_level, 0);
        i_rx_done = 1'b0;
        step();
        i_rx_done = 1'b1;
        i_rx_word = 9'h03C;
        step();
        i_rx_done = 1'b0;
        check("post reset push level", o_level, 1);
        check("post reset push data", o_rd_data, 8'h3C);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
